// File: rtl/circuit_sweep_harness_if.sv
// Result handshake between the sweep harness and its log/host sink.
interface circuit_sweep_harness_if #(
  parameter int IO_WIDTH  = 8,
  parameter int IDX_WIDTH = 8
);
  logic                 res_valid;
  logic                 res_ready;
  logic [IDX_WIDTH-1:0] res_stim;
  logic [IO_WIDTH-1:0]  res_data;

  modport master (output res_valid, res_stim, res_data, input res_ready);
  modport slave  (input res_valid, res_stim, res_data, output res_ready);
endinterface

// File: rtl/circuit_sweep_harness.sv
// Clocked exhaustive-sweep harness: drives index vectors into a combinational circuit,
// captures each settled response and streams it out. Optional macro: SWEEP_SIGNATURE_EN.
module circuit_sweep_harness #(
  parameter int IO_WIDTH      = 8,
  parameter int ITERATIONS    = 256,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 32,
  parameter int IDX_WIDTH     = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [IO_WIDTH-1:0]     dut_in,
  input  logic [IO_WIDTH-1:0]     dut_out,
  circuit_sweep_harness_if.master res,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic [IO_WIDTH-1:0]     signature
);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SETTLE_RELOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX      = IDX_WIDTH'(ITERATIONS - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("circuit_sweep_harness: SETTLE_CYCLES must be >= 1");
  end
  if (ITERATIONS < 1) begin : g_bad_iter
    $error("circuit_sweep_harness: ITERATIONS must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] index;
  logic [SET_W-1:0]     settle_cnt;
  logic                 go, cap, acc, last;

  function automatic logic [IO_WIDTH-1:0] to_io(input logic [IDX_WIDTH-1:0] i);
    logic [IO_WIDTH+IDX_WIDTH-1:0] w;
    w = {{IO_WIDTH{1'b0}}, i};
    return w[IO_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign last = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    cap     = 1'b0;
    acc     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          go      = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_d = S_EMIT;
          cap     = 1'b1;
        end
      end
      S_EMIT: begin
        if (res.res_valid && res.res_ready) begin
          acc     = 1'b1;
          state_d = last ? S_DONE : S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The edge that accepts start is itself a busy edge, so the count begins at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      index         <= '0;
      settle_cnt    <= '0;
      dut_in        <= '0;
      res.res_valid <= 1'b0;
      res.res_stim  <= '0;
      res.res_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cycle_count   <= '0;
    end else begin
      if (busy) cycle_count <= sat_inc(cycle_count);
      if (go) begin
        index       <= '0;
        dut_in      <= '0;
        settle_cnt  <= SETTLE_RELOAD;
        busy        <= 1'b1;
        done        <= 1'b0;
        cycle_count <= CNT_WIDTH'(1);
      end else if (state_q == S_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (cap) begin
        res.res_data  <= dut_out;
        res.res_stim  <= index;
        res.res_valid <= 1'b1;
      end
      if (acc) begin
        res.res_valid <= 1'b0;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          index      <= index + 1'b1;
          dut_in     <= to_io(index + 1'b1);
          settle_cnt <= SETTLE_RELOAD;
        end
      end
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  logic [IO_WIDTH-1:0] sig_rot;
  if (IO_WIDTH == 1) begin : g_sig_1
    assign sig_rot = signature;
  end else begin : g_sig_w
    assign sig_rot = {signature[IO_WIDTH-2:0], signature[IO_WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (rst || go) signature <= '0;
    else if (acc)  signature <= sig_rot ^ res.res_data;
  end
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_circuit_sweep_harness.sv
// Directed bench for circuit_sweep_harness: identity and inverter sweeps, handshake stalls,
// index wrap, mid-sweep reset and start filtering, checked against a beat scoreboard.
module tb_circuit_sweep_harness;
  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [7:0]  dut_in0, dut_out0, dut_in1, dut_out1, sig0, sig1;
  logic        busy0, done0, busy1, done1;
  logic [31:0] cc0, cc1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] stim;
    logic [7:0] data;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  circuit_sweep_harness_if #(.IO_WIDTH(8), .IDX_WIDTH(2)) r0 ();
  circuit_sweep_harness_if #(.IO_WIDTH(8), .IDX_WIDTH(9)) r1 ();

  assign dut_out0 = dut_in0;
  assign dut_out1 = ~dut_in1;

  circuit_sweep_harness #(.IO_WIDTH(8), .ITERATIONS(4), .SETTLE_CYCLES(1), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0), .res(r0),
    .busy(busy0), .done(done0), .cycle_count(cc0), .signature(sig0));

  circuit_sweep_harness #(.IO_WIDTH(8), .ITERATIONS(300), .SETTLE_CYCLES(3), .CNT_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1), .res(r1),
    .busy(busy1), .done(done1), .cycle_count(cc1), .signature(sig1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [8:0] stim, input logic [7:0] data);
    beat_t b;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_beat"}, 64'(stim), 64'h1ff);
    end else begin
      b = sb.pop_front();
      chk({tag, "_stim"}, 64'(stim), 64'(b.stim));
      chk({tag, "_data"}, 64'(data), 64'(b.data));
    end
  endtask

  function automatic logic [7:0] rotx(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7]} ^ d;
  endfunction

  // Identity sweep on u0; optional start pulse mid-sweep and on the final handshake.
  task automatic sweep0(input int pulse_at, input bit pulse_last);
    int edges, guard;
    logic [7:0] sig_m;
    sig_m = 8'h00;
    r0.res_ready = 1'b1;
    start0 = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{stim: 9'(i), data: 8'(i)});
    tick();
    start0 = 1'b0;
    edges = 1;
    guard = 0;
    chk("u0_start_busy", 64'(busy0), 64'd1);
    chk("u0_start_done", 64'(done0), 64'd0);
    chk("u0_start_cc", 64'(cc0), 64'd1);
    while (!done0 && guard < 100) begin
      start0 = (guard == pulse_at) ? 1'b1 : 1'b0;
      if (r0.res_valid && r0.res_ready) begin
        if (pulse_last && r0.res_stim == 2'd3) start0 = 1'b1;
        pop_cmp("u0_beat", 9'(r0.res_stim), r0.res_data);
`ifdef SWEEP_SIGNATURE_EN
        sig_m = rotx(sig_m, r0.res_data);
`endif
      end
      tick();
      edges++;
      guard++;
    end
    start0 = 1'b0;
    chk("u0_done", 64'(done0), 64'd1);
    chk("u0_edges", 64'(edges), 64'd9);
    chk("u0_cycle_count", 64'(cc0), 64'd9);
    chk("u0_sb_empty", 64'(sb.size()), 64'd0);
    chk("u0_signature", 64'(sig0), 64'(sig_m));
    tick();
    chk("u0_done_hold", 64'(done0), 64'd1);
    chk("u0_busy_idle", 64'(busy0), 64'd0);
    chk("u0_cc_frozen", 64'(cc0), 64'd9);
    chk("u0_dut_in_hold", 64'(dut_in0), 64'd3);
  endtask

  // Inverter sweep on u1 with optional 5-cycle stall on beat 2 and optional abort at beat abort_at.
  task automatic sweep1(input bit stall_en, input int abort_at);
    int edges, guard, stall, beats;
    r1.res_ready = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 300; i++) sb.push_back('{stim: 9'(i), data: ~8'(i)});
    tick();
    start1 = 1'b0;
    edges = 1;
    guard = 0;
    stall = 0;
    beats = 0;
    while (!done1 && guard < 5000) begin
      if (abort_at >= 0 && busy1 && !r1.res_valid && dut_in1 == 8'(abort_at)) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("u1_abort_valid", 64'(r1.res_valid), 64'd0);
        chk("u1_abort_busy", 64'(busy1), 64'd0);
        chk("u1_abort_done", 64'(done1), 64'd0);
        chk("u1_abort_cc", 64'(cc1), 64'd0);
        chk("u1_abort_dut_in", 64'(dut_in1), 64'd0);
        chk("u1_abort_stim", 64'(r1.res_stim), 64'd0);
        chk("u1_abort_data", 64'(r1.res_data), 64'd0);
        chk("u1_abort_beats", 64'(beats), 64'(abort_at));
        sb.delete();
        return;
      end
      if (r1.res_valid) begin
        if (stall_en && r1.res_stim == 9'd2 && stall < 5) begin
          r1.res_ready = 1'b0;
          chk("u1_stall_stim", 64'(r1.res_stim), 64'd2);
          chk("u1_stall_data", 64'(r1.res_data), 64'hfd);
          stall++;
        end else begin
          r1.res_ready = 1'b1;
          if (r1.res_stim == 9'd256) chk("u1_wrap_dut_in", 64'(dut_in1), 64'h00);
          pop_cmp("u1_beat", r1.res_stim, r1.res_data);
          beats++;
        end
      end
      tick();
      edges++;
      guard++;
    end
    r1.res_ready = 1'b1;
    chk("u1_done", 64'(done1), 64'd1);
    chk("u1_beats", 64'(beats), 64'd300);
    chk("u1_sb_empty", 64'(sb.size()), 64'd0);
    chk("u1_cycle_count", 64'(cc1), 64'(edges));
    chk("u1_edges", 64'(edges), stall_en ? 64'd1206 : 64'd1201);
    chk("u1_signature", 64'(sig1), 64'(sig1_model()));
  endtask

  // Signature model for one full inverter sweep of 300 vectors.
  function automatic logic [7:0] sig1_model();
    logic [7:0] s;
    s = 8'h00;
`ifdef SWEEP_SIGNATURE_EN
    for (int i = 0; i < 300; i++) s = rotx(s, ~8'(i));
`endif
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    r0.res_ready = 1'b0;
    r1.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid0", 64'(r0.res_valid), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_cc0", 64'(cc0), 64'd0);
    chk("rst_dut_in0", 64'(dut_in0), 64'd0);
    chk("rst_sig0", 64'(sig0), 64'd0);
    chk("rst_valid1", 64'(r1.res_valid), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_start", 64'(busy0), 64'd0);

    sweep0(-1, 1'b0);
    sweep0(2, 1'b0);
    sweep0(-1, 1'b1);

    sweep1(1'b1, -1);
    sweep1(1'b0, 5);
    sweep1(1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
